// File: rtl/mux_pkg.sv
// Shared constants for the 2:1 selector and its bit-slice.
package mux_pkg;

  // Default data width of the selector.
  localparam int MUX_DEFAULT_WIDTH = 1;

  // Named select codes: which input drives the result.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_bit.sv
// One-bit and/not/or selector slice: o_out = i_a when i_sel=0, i_b when i_sel=1.
module mux_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_sel,
  output logic o_out
);

  logic w_take_a;
  logic w_take_b;
  logic w_agree;

  // Gate form of the select. The extra (a & b) consensus term is logically
  // redundant, but it keeps the output known when sel is X and both inputs
  // are 1. Without it, X would propagate in that case.
  // (When both inputs are 0, the two product terms are already 0.)
  always_comb begin
    w_take_a = i_a & ~i_sel;
    w_take_b = i_b & i_sel;
    w_agree  = i_a & i_b;
    o_out    = w_take_a | w_take_b | w_agree;
  end

endmodule : mux_bit

// File: rtl/mux.sv
// WIDTH-bit 2:1 selector.
//   out   : combinational result, built from per-bit gate slices.
//   out_q : copy of out registered on clk.
module mux
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] r_out_q;

  // One slice per data bit. Every slice shares the same select line.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      mux_bit u_bit (
        .i_a   (a[gi]),
        .i_b   (b[gi]),
        .i_sel (sel),
        .o_out (w_out[gi])
      );
    end
  endgenerate

  // Register the combinational result.
  // Reset clears the register, and it wins over data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_q <= '0;
    end else begin
      r_out_q <= w_out;
    end
  end

  assign out   = w_out;
  assign out_q = r_out_q;

endmodule : mux

// File: tb/tb_mux.sv
// Directed checks of the 2:1 selector at WIDTH=1 and WIDTH=8.
module tb_mux;
  import mux_pkg::*;

  logic       clk;
  int         n_vec;
  int         n_err;

  // WIDTH=1 instance signals
  logic       rst1;
  logic       a1;
  logic       b1;
  logic       sel1;
  logic       out1;
  logic       outq1;

  // WIDTH=8 instance signals
  logic       rst8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       sel8;
  logic [7:0] out8;
  logic [7:0] outq8;

  logic [7:0] truth;
  logic [2:0] idx;

  mux #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .a     (a1),
    .b     (b1),
    .sel   (sel1),
    .out   (out1),
    .out_q (outq1)
  );

  mux #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .reset (rst8),
    .a     (a8),
    .b     (b8),
    .sel   (sel8),
    .out   (out8),
    .out_q (outq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // Truth table indexed by {a,b,sel}: 000..111 -> 0,0,0,1,1,0,1,1
    truth = 8'b1101_1000;
    rst1 = 1'b1;
    a1 = 1'b0;
    b1 = 1'b0;
    sel1 = SEL_A;
    rst8 = 1'b0;
    a8 = 8'h00;
    b8 = 8'h00;
    sel8 = SEL_A;

    // 1. WIDTH=1 truth-table sweep. Reset is held and must not affect out.
    for (int i = 0; i < 8; i++) begin
      idx = i[2:0];
      a1 = idx[2];
      b1 = idx[1];
      sel1 = idx[0];
      #10;
      check_val($sformatf("tt_%0d%0d%0d", idx[2], idx[1], idx[0]), {63'd0, out1}, {63'd0, truth[idx]});
    end
    @(negedge clk);
    check_val("w1_outq_reset", {63'd0, outq1}, 64'd0);
    rst1 = 1'b0;
    a1 = 1'b1;
    b1 = 1'b0;
    sel1 = SEL_A;
    @(posedge clk); #1;
    check_val("w1_outq_load", {63'd0, outq1}, 64'd1);

    // 2. WIDTH=8 combinational select
    a8 = 8'hA5;
    b8 = 8'h3C;
    sel8 = SEL_A;
    #1 check_val("w8_sel0", {56'd0, out8}, 64'hA5);
    sel8 = SEL_B;
    #1 check_val("w8_sel1", {56'd0, out8}, 64'h3C);
    @(negedge clk);
    sel8 = SEL_A;
    #1 check_val("w8_midcycle", {56'd0, out8}, 64'hA5);

    // 3. Reset held for two edges; out keeps tracking inputs
    @(posedge clk); #1;
    rst8 = 1'b1;
    a8 = 8'hFF;
    sel8 = SEL_A;
    @(posedge clk); #1;
    check_val("rst_e1_outq", {56'd0, outq8}, 64'h00);
    check_val("rst_e1_out", {56'd0, out8}, 64'hFF);
    @(posedge clk); #1;
    check_val("rst_e2_outq", {56'd0, outq8}, 64'h00);
    check_val("rst_e2_out", {56'd0, out8}, 64'hFF);
    rst8 = 1'b0;
    #2 check_val("rst_off_pre", {56'd0, outq8}, 64'h00);
    @(posedge clk); #1;
    check_val("rst_off_load", {56'd0, outq8}, 64'hFF);

    // 4. Registered latency
    a8 = 8'h11;
    b8 = 8'h22;
    sel8 = SEL_A;
    @(posedge clk); #1;
    check_val("lat_base", {56'd0, outq8}, 64'h11);
    sel8 = SEL_B;
    #1 check_val("lat_out", {56'd0, out8}, 64'h22);
    check_val("lat_hold", {56'd0, outq8}, 64'h11);
    @(negedge clk);
    check_val("lat_hold_neg", {56'd0, outq8}, 64'h11);
    @(posedge clk); #1;
    check_val("lat_load", {56'd0, outq8}, 64'h22);

    // 5. Reset mid-stream clears out_q on that same edge
    rst8 = 1'b1;
    #1 check_val("mid_pre", {56'd0, outq8}, 64'h22);
    @(posedge clk); #1;
    check_val("mid_outq", {56'd0, outq8}, 64'h00);
    check_val("mid_out", {56'd0, out8}, 64'h22);
    rst8 = 1'b0;

    // 6. Equal inputs with an unknown select
    a8 = 8'h5A;
    b8 = 8'h5A;
    sel8 = 1'bx;
    #1 check_val("x_sel_out", {56'd0, out8}, 64'h5A);
    check_val("x_sel_known", {63'd0, (^out8 === 1'bx)}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mux
